// File: rtl/ahb3lite_apb_bridge.sv
// ahb3lite_apb_bridge
//   AHB3-Lite slave to APB4 master bridge on a single clock (PCLK).
//   Every accepted AHB beat becomes one APB SETUP/ACCESS sequence; AHB is
//   stalled through HREADYOUT and APB errors become the two-cycle AHB ERROR
//   response.
//   Optional feature: define APB_BRIDGE_TIMEOUT_EN to abort an ACCESS phase
//   that has waited TIMEOUT cycles for PREADY and answer it with ERROR.
module ahb3lite_apb_bridge #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32,
    parameter int PADDR_SIZE = 8,
    parameter int PDATA_SIZE = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    PRESETn,
    input  logic                    PCLK,
    input  logic                    HSEL,
    input  logic [HADDR_SIZE-1:0]   HADDR,
    input  logic [HDATA_SIZE-1:0]   HWDATA,
    output logic [HDATA_SIZE-1:0]   HRDATA,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic [1:0]              HTRANS,
    input  logic                    HMASTLOCK,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [2:0]              PPROT,
    output logic                    PWRITE,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int         NBYTES   = PDATA_SIZE / 8;
    localparam int         LSB      = $clog2(NBYTES);
    localparam logic [2:0] MAX_SIZE = 3'(LSB);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t state_reg, state_next;

    logic                    accept;
    logic                    size_err;
    logic [LSB-1:0]          addr_lo;
    logic [NBYTES-1:0]       strb_dec;

    logic [PADDR_SIZE-1:0]   paddr_reg;
    logic                    pwrite_reg;
    logic [NBYTES-1:0]       pstrb_reg;
    logic [2:0]              pprot_reg;
    logic [PDATA_SIZE-1:0]   pwdata_reg;
    logic [HDATA_SIZE-1:0]   hrdata_reg;

    // NONSEQ and SEQ both carry HTRANS[1]; IDLE/BUSY are answered zero-wait
    assign accept   = HSEL & HREADY & HTRANS[1];
    assign size_err = (HSIZE > MAX_SIZE);
    assign addr_lo  = HADDR[LSB-1:0];

    // A byte lane is strobed when it falls in the same naturally aligned
    // block of 2**HSIZE bytes as the transfer address.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_strb
        localparam logic [LSB-1:0] LANE = LSB'(gi);
        assign strb_dec[gi] = ((LANE >> HSIZE) == (addr_lo >> HSIZE));
    end

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT > 255) ? 16 : 8;

    logic [TO_W-1:0] timeout_cnt_reg;
    logic            timeout_hit;

    // The wait that would make the count reach TIMEOUT aborts the access
    assign timeout_hit = (timeout_cnt_reg == TO_W'(TIMEOUT - 1));

    // PREADY wait counter: cleared on the way into ACCESS, counts stalled cycles
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == ST_SETUP) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == ST_ACCESS && !PREADY) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    // Burst type, lock, the SEQ/NONSEQ distinction, upper address bits and
    // the cacheable/bufferable HPROT bits have no APB counterpart.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HBURST, HMASTLOCK, HTRANS[0], HADDR, HPROT[3:2]};

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state decode and the handshake outputs that follow the state
    always_comb begin
        state_next = state_reg;
        HREADYOUT  = 1'b0;
        HRESP      = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                HREADYOUT = 1'b1;
                if (accept) begin
                    if (size_err) begin
                        state_next = ST_ERR1;
                    end else if (HWRITE) begin
                        state_next = ST_WDATA;
                    end else begin
                        state_next = ST_SETUP;
                    end
                end
            end
            ST_WDATA: begin
                state_next = ST_SETUP;
            end
            ST_SETUP: begin
                PSEL       = 1'b1;
                state_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    state_next = PSLVERR ? ST_ERR1 : ST_IDLE;
                end
`ifdef APB_BRIDGE_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_next = ST_ERR1;
                end
`endif
            end
            ST_ERR1: begin
                HRESP      = 1'b1;
                state_next = ST_ERR2;
            end
            ST_ERR2: begin
                // The master cancels its next beat here, so nothing is accepted
                HREADYOUT  = 1'b1;
                HRESP      = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // APB address-phase registers, captured once per accepted legal transfer
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            paddr_reg  <= '0;
            pwrite_reg <= 1'b0;
            pstrb_reg  <= '0;
            pprot_reg  <= '0;
        end else if (state_reg == ST_IDLE && accept && !size_err) begin
            paddr_reg  <= HADDR[PADDR_SIZE-1:0];
            pwrite_reg <= HWRITE;
            pstrb_reg  <= HWRITE ? strb_dec : '0;
            pprot_reg  <= {~HPROT[0], 1'b1, HPROT[1]};
        end
    end

    // Write data arrives in the AHB data phase, one cycle after the address
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pwdata_reg <= '0;
        end else if (state_reg == ST_WDATA) begin
            pwdata_reg <= HWDATA;
        end
    end

    // Read data is captured on a clean completion and held until the next one
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            hrdata_reg <= '0;
        end else if (state_reg == ST_ACCESS && PREADY && !PSLVERR && !pwrite_reg) begin
            hrdata_reg <= PRDATA;
        end
    end

    assign PADDR  = paddr_reg;
    assign PWRITE = pwrite_reg;
    assign PSTRB  = pstrb_reg;
    assign PPROT  = pprot_reg;
    assign PWDATA = pwdata_reg;
    assign HRDATA = hrdata_reg;

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// tb_ahb3lite_apb_bridge
//   Drives AHB transfers into the bridge, plays an APB slave with chosen
//   wait states and error responses, and compares every cycle-level
//   observation against expectations derived from transfer parameters.
module tb_ahb3lite_apb_bridge;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic        PSEL;
    logic        PENABLE;
    logic [2:0]  PPROT;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] hrdata_model;

    ahb3lite_apb_bridge #(
        .HADDR_SIZE(32), .HDATA_SIZE(32), .PADDR_SIZE(8), .PDATA_SIZE(32), .TIMEOUT(TO)
    ) dut (
        .PRESETn(PRESETn), .PCLK(PCLK), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PPROT(PPROT), .PWRITE(PWRITE),
        .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Byte lanes covered by a 2**size-byte access at addr on a 4-byte bus
    function automatic logic [3:0] strb_model(input logic [31:0] addr, input logic [2:0] size,
                                               input logic wr);
        int bytes = 1 << size;
        int base  = (int'(addr % 4) / bytes) * bytes;
        logic [3:0] s = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (wr && i >= base && i < base + bytes) s[i] = 1'b1;
        return s;
    endfunction

    // One AHB transfer, started at a negedge with the bridge idle; returns
    // at the negedge of its completing HREADYOUT=1 cycle (IDLE, so the
    // caller may present the next address phase right there).
    task automatic do_xfer(input string tag, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [3:0] prot,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int waits, input logic err);
        int   low = 0, psel_n = 0, pen_n = 0, acc = 0, cyc = 0;
        bit   done = 0, end_resp = 0, last_low_resp = 0;
        bit   oversize = (size > 3'd2);
        bit   eff_err  = err;
        int   exp_acc  = waits + 1;
        int   exp_low, exp_psel;
        logic [2:0] exp_prot = {~prot[0], 1'b1, prot[1]};
        logic [3:0] exp_strb = strb_model(addr, size, wr);
`ifdef APB_BRIDGE_TIMEOUT_EN
        if (waits >= TO) begin
            exp_acc = TO;
            eff_err = 1;
        end
`endif
        if (oversize) begin
            exp_acc  = 0;
            eff_err  = 1;
            exp_low  = 1;
            exp_psel = 0;
        end else begin
            exp_low  = (wr ? 3 : 2) + exp_acc - 1 + (eff_err ? 1 : 0);
            exp_psel = exp_acc + 1;
        end
        if (!wr && !eff_err) hrdata_model = rdata;

        n_cmp++;
        if (HREADYOUT !== 1'b1) begin
            n_bad++;
            $display("FAIL %s addr_phase_ready: HREADYOUT=%b required 1", tag, HREADYOUT);
        end
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        HPROT  = prot;
        HREADY = 1'b1;
        HBURST = 3'($urandom_range(0, 7));

        while (!done && cyc < 60) begin
            @(negedge PCLK);
            cyc++;
            if (cyc == 1) begin
                HSEL   = 1'b0;
                HTRANS = 2'b00;
                HADDR  = $urandom;
                HWDATA = wdata;
            end else begin
                HWDATA = $urandom;
            end
            if (HREADYOUT) begin
                done     = 1;
                end_resp = HRESP;
                n_cmp++;
                if (HRDATA !== hrdata_model) begin
                    n_bad++;
                    $display("FAIL %s hrdata: got %h required %h", tag, HRDATA, hrdata_model);
                end
            end else begin
                low++;
                last_low_resp = HRESP;
            end
            if (PSEL) begin
                psel_n++;
                n_cmp++;
                if (PADDR !== addr[7:0] || PWRITE !== wr || PSTRB !== exp_strb
                    || PPROT !== exp_prot) begin
                    n_bad++;
                    $display("FAIL %s apb_ctrl: paddr=%h pwrite=%b pstrb=%b pprot=%b required %h %b %b %b",
                             tag, PADDR, PWRITE, PSTRB, PPROT, addr[7:0], wr, exp_strb, exp_prot);
                end
                if (wr) begin
                    n_cmp++;
                    if (PWDATA !== wdata) begin
                        n_bad++;
                        $display("FAIL %s pwdata: got %h required %h", tag, PWDATA, wdata);
                    end
                end
            end
            if (PSEL && PENABLE) begin
                pen_n++;
                acc++;
                PREADY  = (acc > waits);
                PSLVERR = PREADY && err;
                PRDATA  = PREADY ? rdata : $urandom;
            end else begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
                PRDATA  = $urandom;
            end
        end

        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL %s completion: no HREADYOUT=1 within 60 cycles", tag);
        end
        n_cmp++;
        if (low != exp_low) begin
            n_bad++;
            $display("FAIL %s stall_cycles: got %0d required %0d", tag, low, exp_low);
        end
        n_cmp++;
        if (end_resp != eff_err || (low > 0 && last_low_resp != eff_err)) begin
            n_bad++;
            $display("FAIL %s hresp: end=%0d last_stall=%0d required %0d", tag, end_resp,
                     last_low_resp, eff_err);
        end
        n_cmp++;
        if (psel_n != exp_psel || pen_n != exp_acc) begin
            n_bad++;
            $display("FAIL %s apb_cycles: psel=%0d penable=%0d required %0d %0d", tag, psel_n,
                     pen_n, exp_psel, exp_acc);
        end
        $display("xfer %s wr=%0d addr=%h size=%0d waits=%0d err=%0d stall=%0d resp=%0d",
                 tag, wr, addr, size, waits, eff_err, low, end_resp);
        if (eff_err && done) begin
            @(negedge PCLK);
            n_cmp++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin
                n_bad++;
                $display("FAIL %s post_error_idle: hreadyout=%b hresp=%b psel=%b required 1 0 0",
                         tag, HREADYOUT, HRESP, PSEL);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({HREADYOUT, HRESP, PSEL, PENABLE, PWRITE} !== 5'b10000) begin
            n_bad++;
            $display("FAIL %s handshake: hreadyout/hresp/psel/penable/pwrite=%b required 10000",
                     tag, {HREADYOUT, HRESP, PSEL, PENABLE, PWRITE});
        end
        n_cmp++;
        if (PSTRB !== 4'd0 || PADDR !== 8'd0 || PWDATA !== 32'd0 || PPROT !== 3'd0
            || HRDATA !== 32'd0) begin
            n_bad++;
            $display("FAIL %s datapath: pstrb=%h paddr=%h pwdata=%h pprot=%h hrdata=%h required 0",
                     tag, PSTRB, PADDR, PWDATA, PPROT, HRDATA);
        end
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        #3;
        check_reset_values("reset");
        hrdata_model = 32'd0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        check_reset_values("after_reset");
    endtask

    task automatic test_idle_busy();
        for (int i = 0; i < 8; i++) begin
            HSEL   = 1'($urandom);
            HTRANS = 2'($urandom_range(0, 1));
            HREADY = 1'b1;
            HADDR  = $urandom;
            HWRITE = 1'($urandom);
            HSIZE  = 3'd2;
            @(negedge PCLK);
            n_cmp++;
            if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_busy: hreadyout=%b hresp=%b psel=%b required 1 0 0",
                         HREADYOUT, HRESP, PSEL);
            end
        end
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        $display("idle/busy: 8 cycles of zero-wait OKAY observed");
    endtask

    task automatic test_directed();
        do_xfer("word_write", 1'b1, 32'h14, 3'd2, 4'b0011, 32'hDEADBEEF, 32'h0, 0, 1'b0);
        @(negedge PCLK);
        do_xfer("delayed_read", 1'b0, 32'h20, 3'd2, 4'b0000, 32'h0, 32'h12345678, 3, 1'b0);
        @(negedge PCLK);
        do_xfer("byte_write", 1'b1, 32'h03, 3'd0, 4'b0001, 32'hAA000000, 32'h0, 0, 1'b0);
        @(negedge PCLK);
        do_xfer("half_write", 1'b1, 32'h02, 3'd1, 4'b0010, 32'h5A5A0000, 32'h0, 1, 1'b0);
        @(negedge PCLK);
        do_xfer("err_write", 1'b1, 32'h40, 3'd2, 4'b0000, 32'h01020304, 32'h0, 0, 1'b1);
        do_xfer("err_read", 1'b0, 32'h44, 3'd2, 4'b0000, 32'h0, 32'hFFFF0000, 2, 1'b1);
        do_xfer("oversize", 1'b0, 32'h48, 3'd3, 4'b0000, 32'h0, 32'h0BADBAD0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_xfer("b2b_read", 1'b0, 32'h30, 3'd2, 4'b0001, 32'h0, 32'hCAFEF00D, 0, 1'b0);
        do_xfer("b2b_write", 1'b1, 32'h34, 3'd2, 4'b0010, 32'h76543210, 32'h0, 0, 1'b0);
        do_xfer("b2b_read2", 1'b0, 32'h38, 3'd1, 4'b0011, 32'h0, 32'h00C0FFEE, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  size = 3'($urandom_range(0, 3));
            logic [31:0] addr = $urandom;
            if (size <= 3'd2) addr = addr & ~((32'd1 << size) - 32'd1);
            do_xfer($sformatf("rnd%0d", i), 1'($urandom), addr, size, 4'($urandom),
                    $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
            repeat ($urandom_range(0, 2)) @(negedge PCLK);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h5C;
        HWRITE = 1'b0;
        HSIZE  = 3'd2;
        HPROT  = 4'b0011;
        HREADY = 1'b1;
        PREADY = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge PCLK);
            HSEL   = 1'b0;
            HTRANS = 2'b00;
            if (PSEL && PENABLE) seen = 1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL reset_mid reach_access: PENABLE never seen within 10 cycles");
        end
        #2;
        PRESETn = 1'b0;
        #1;
        n_cmp++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || HRESP !== 1'b0 || HREADYOUT !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid immediate: psel=%b penable=%b hresp=%b hreadyout=%b required 0 0 0 1",
                     PSEL, PENABLE, HRESP, HREADYOUT);
        end
        check_reset_values("reset_mid");
        hrdata_model = 32'd0;
        @(negedge PCLK);
        PRESETn = 1'b1;
        @(negedge PCLK);
        $display("reset during ACCESS: outputs observed after asynchronous assertion");
    endtask

`ifdef APB_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        do_xfer("timeout_read", 1'b0, 32'h60, 3'd2, 4'b0000, 32'h0, 32'h11111111, 50, 1'b0);
        do_xfer("timeout_edge", 1'b1, 32'h64, 3'd2, 4'b0000, 32'h22222222, 32'h0, TO - 1, 1'b0);
    endtask
`endif

    initial begin
        HSEL      = 1'b0;
        HADDR     = '0;
        HWDATA    = '0;
        HWRITE    = 1'b0;
        HSIZE     = 3'd2;
        HBURST    = 3'd0;
        HPROT     = 4'd0;
        HTRANS    = 2'b00;
        HMASTLOCK = 1'b0;
        HREADY    = 1'b1;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRESETn   = 1'b0;
        hrdata_model = 32'd0;

        test_reset();
        test_idle_busy();
        test_directed();
        @(negedge PCLK);
        test_back_to_back();
        @(negedge PCLK);
        test_random();
        @(negedge PCLK);
        test_reset_mid();
`ifdef APB_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
